afisaj_7seg: RTL and testbench

AFISAJ_7SEG -- requirements
Module: afisaj_7seg

---
 rtl/afisaj_7seg.sv | 155 +++++++++++++++
 tb/tb_afisaj_7seg.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/afisaj_7seg.sv
// afisaj_7seg -- multiplexed 4-digit 7-segment driver for an MM:SS stopwatch.
//
// A prescaler divides clk down to one "tick" per digit slot. Each tick advances
// the scan index 3->0->1->2->3; the four BCD digits are snapshotted on the 3->0
// tick so a whole frame always shows one consistent time value. While paused,
// the display blinks with a half-period of BLINK_FRAMES frames.
//
// Ports:
//   clk        : single clock, all state on its rising edge
//   reset      : asynchronous, active-high reset
//   MIN_BCD1   : minutes tens digit   (shown on an[3])
//   MIN_BCD0   : minutes units digit  (shown on an[2])
//   SEC_BCD1   : seconds tens digit   (shown on an[1])
//   SEC_BCD0   : seconds units digit  (shown on an[0])
//   pauza      : stopwatch paused, enables blinking
//   blank_lz   : blank the minutes tens digit when it is 0
//   an         : active-low digit enables (registered)
//   seg        : active-low segments {g,f,e,d,c,b,a} (registered)
//   dp         : active-low decimal point, lit in slot 2 only (registered)
module afisaj_7seg #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] MIN_BCD1,
  input  logic [3:0] MIN_BCD0,
  input  logic [3:0] SEC_BCD1,
  input  logic [3:0] SEC_BCD0,
  input  logic       pauza,
  input  logic       blank_lz,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int             PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX  = PW'(REFRESH_DIV - 1);
  localparam logic [7:0]     FRAME_MAX  = 8'(BLINK_FRAMES - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   snap_q, snap_d;       // {MIN_BCD1, MIN_BCD0, SEC_BCD1, SEC_BCD0}
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          blink_on_q, blink_on_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          tick;
  logic          frame_start;
  logic [15:0]   cur_snap;
  logic [3:0]    digit;
  logic [6:0]    seg_dec;
  logic          lz_blank;
  logic          visible;

  // Next-state logic. Outputs are computed for the slot being entered (idx_d),
  // and on the frame boundary they decode from the values being captured this
  // very edge, so slot 0 never shows a stale digit from the previous frame.
  always_comb begin
    presc_d     = presc_q;
    idx_d       = idx_q;
    snap_d      = snap_q;
    frame_cnt_d = frame_cnt_q;
    blink_on_d  = blink_on_q;
    an_d        = an_q;
    seg_d       = seg_q;
    dp_d        = dp_q;

    tick        = (presc_q == PRESC_MAX);
    frame_start = tick && (idx_q == 2'd3);

    presc_d = tick ? '0 : presc_q + 1'b1;
    if (tick) begin
      idx_d = idx_q + 2'd1;
    end

    cur_snap = frame_start ? {MIN_BCD1, MIN_BCD0, SEC_BCD1, SEC_BCD0} : snap_q;
    snap_d   = cur_snap;

    // Blink phase only advances while paused; releasing pause restarts the
    // half-period so the next pause always begins with a visible phase.
    if (!pauza) begin
      blink_on_d  = 1'b1;
      frame_cnt_d = 8'd0;
    end else if (frame_start) begin
      if (frame_cnt_q == FRAME_MAX) begin
        frame_cnt_d = 8'd0;
        blink_on_d  = ~blink_on_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end

    case (idx_d)
      2'd0:    digit = cur_snap[3:0];
      2'd1:    digit = cur_snap[7:4];
      2'd2:    digit = cur_snap[11:8];
      default: digit = cur_snap[15:12];
    endcase

    case (digit)
      4'd0:    seg_dec = 7'b1000000;
      4'd1:    seg_dec = 7'b1111001;
      4'd2:    seg_dec = 7'b0100100;
      4'd3:    seg_dec = 7'b0110000;
      4'd4:    seg_dec = 7'b0011001;
      4'd5:    seg_dec = 7'b0010010;
      4'd6:    seg_dec = 7'b0000010;
      4'd7:    seg_dec = 7'b1111000;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0010000;
      default: seg_dec = 7'b0111111;   // non-BCD values show a dash
    endcase

    lz_blank = blank_lz && (idx_d == 2'd3) && (digit == 4'd0);
    visible  = blink_on_d && !lz_blank;

    if (tick) begin
      an_d  = visible ? ~(4'b0001 << idx_d) : 4'b1111;
      seg_d = visible ? seg_dec : 7'b1111111;
      dp_d  = !(visible && (idx_d == 2'd2));
    end
  end

  // State registers; reset puts the scan at slot 3 so the first tick lands on
  // slot 0 and captures a fresh frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q     <= '0;
      idx_q       <= 2'd3;
      snap_q      <= 16'd0;
      frame_cnt_q <= 8'd0;
      blink_on_q  <= 1'b1;
      an_q        <= 4'b1111;
      seg_q       <= 7'b1111111;
      dp_q        <= 1'b1;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      frame_cnt_q <= frame_cnt_d;
      blink_on_q  <= blink_on_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_afisaj_7seg.sv
// tb_afisaj_7seg -- scoreboard bench for afisaj_7seg with REFRESH_DIV=4 and
// BLINK_FRAMES=2. Stimulus pushes expected outputs tagged with the clk edge
// number (counted from reset release) at which they must appear; a separate
// monitor pops and compares them on the falling edge after that clk edge.
// With REFRESH_DIV=4, slot i of frame f is entered on edge 16*f + 4*i + 4.
module tb_afisaj_7seg;

  logic       clk;
  logic       reset;
  logic [3:0] min_bcd1, min_bcd0, sec_bcd1, sec_bcd0;
  logic       pauza;
  logic       blank_lz;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    bit         full;
  } exp_t;

  exp_t sb_q[$];
  int   edge_cnt = 0;
  int   checks   = 0;
  int   failures = 0;

  // Expected pattern for the pause phase: M1=0, M0=2, S1=C, S0=7, blank_lz=0.
  logic [3:0] pat_an[4];
  logic [6:0] pat_seg[4];
  logic       pat_dp[4];

  afisaj_7seg #(.REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .MIN_BCD1 (min_bcd1),
    .MIN_BCD0 (min_bcd0),
    .SEC_BCD1 (sec_bcd1),
    .SEC_BCD0 (sec_bcd0),
    .pauza    (pauza),
    .blank_lz (blank_lz),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: number of rising edges seen since reset was last released.
  always @(posedge clk) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [3:0] e_an,
                             input logic [6:0] e_seg, input logic e_dp, input bit full);
    bit bad;
    checks++;
    bad = (an !== e_an);
    if (full) bad = bad || (seg !== e_seg) || (dp !== e_dp);
    if (bad) begin
      failures++;
      if (full)
        $display("[TB] FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                 name, an, seg, dp, e_an, e_seg, e_dp);
      else
        $display("[TB] FAIL %s: got an=%b, expected an=%b", name, an, e_an);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] m1, input logic [3:0] m0,
                               input logic [3:0] s1, input logic [3:0] s0,
                               input logic pz, input logic blz);
    min_bcd1 = m1;
    min_bcd0 = m0;
    sec_bcd1 = s1;
    sec_bcd0 = s0;
    pauza    = pz;
    blank_lz = blz;
  endtask

  task automatic pushExp(input int cyc, input logic [3:0] e_an, input logic [6:0] e_seg,
                         input logic e_dp, input bit full);
    exp_t e;
    e.cyc  = cyc;
    e.an   = e_an;
    e.seg  = e_seg;
    e.dp   = e_dp;
    e.full = full;
    sb_q.push_back(e);
  endtask

  task automatic waitEdge(input int n);
    while (edge_cnt < n) @(negedge clk);
  endtask

  // Monitor: on each falling edge, compare every expectation due at the
  // current edge count; an expectation whose edge has already passed is a miss.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= edge_cnt) begin
      exp_t e;
      e = sb_q.pop_front();
      if (e.cyc < edge_cnt) begin
        checks++;
        failures++;
        $display("[TB] FAIL missed_e%0d: got edge %0d, expected edge %0d", e.cyc, edge_cnt, e.cyc);
      end else begin
        checkOutput($sformatf("edge%0d", e.cyc), e.an, e.seg, e.dp, e.full);
      end
    end
  end

  initial begin
    pat_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    pat_seg = '{7'b1111000, 7'b0111111, 7'b0100100, 7'b1000000};
    pat_dp  = '{1'b1, 1'b1, 1'b0, 1'b1};

    reset = 1'b1;
    applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0);

    // Reset state, dark until first tick, then frame 0 with 1,2,3,4.
    pushExp(0,  4'b1111, 7'b1111111, 1'b1, 1);
    pushExp(1,  4'b1111, 7'b1111111, 1'b1, 1);
    pushExp(2,  4'b1111, 7'b1111111, 1'b1, 1);
    pushExp(3,  4'b1111, 7'b1111111, 1'b1, 1);
    pushExp(4,  4'b1110, 7'b0011001, 1'b1, 1);
    pushExp(8,  4'b1101, 7'b0110000, 1'b1, 1);
    pushExp(12, 4'b1011, 7'b0100100, 1'b0, 1);
    pushExp(16, 4'b0111, 7'b1111001, 1'b1, 1);
    // Frame 1: S0 changes 4->7 during slot 1, must not tear this frame.
    pushExp(20, 4'b1110, 7'b0011001, 1'b1, 1);
    pushExp(24, 4'b1101, 7'b0110000, 1'b1, 1);
    pushExp(28, 4'b1011, 7'b0100100, 1'b0, 1);
    pushExp(32, 4'b0111, 7'b1111001, 1'b1, 1);
    // Frame 2: new S0 visible; other inputs change mid-frame.
    pushExp(36, 4'b1110, 7'b1111000, 1'b1, 1);
    pushExp(40, 4'b1101, 7'b0110000, 1'b1, 1);
    pushExp(44, 4'b1011, 7'b0100100, 1'b0, 1);
    pushExp(48, 4'b0111, 7'b1111001, 1'b1, 1);
    // Frame 3: S1=C shows a dash, M1=0 with blank_lz=1 is blanked.
    pushExp(52, 4'b1110, 7'b1111000, 1'b1, 1);
    pushExp(56, 4'b1101, 7'b0111111, 1'b1, 1);
    pushExp(60, 4'b1011, 7'b0100100, 1'b0, 1);
    pushExp(64, 4'b1111, 7'b1111111, 1'b1, 1);
    // Frame 4: blank_lz=0 so the leading zero is shown.
    pushExp(68, 4'b1110, 7'b1111000, 1'b1, 1);
    pushExp(72, 4'b1101, 7'b0111111, 1'b1, 1);
    pushExp(76, 4'b1011, 7'b0100100, 1'b0, 1);
    pushExp(80, 4'b0111, 7'b1000000, 1'b1, 1);

    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    waitEdge(24);
    applyStimulus(4'd1, 4'd2, 4'd3, 4'd7, 1'b0, 1'b0);
    waitEdge(40);
    applyStimulus(4'd0, 4'd2, 4'hC, 4'd7, 1'b0, 1'b1);
    waitEdge(64);
    applyStimulus(4'd0, 4'd2, 4'hC, 4'd7, 1'b0, 1'b0);

    // Pause raised early in frame 5: frames 5-6 visible, 7-8 dark, 9-10
    // visible, frame 11 dark until pause drops after slot 1.
    for (int f = 5; f <= 13; f++) begin
      for (int i = 0; i < 4; i++) begin
        if (!(f == 13 && i == 3)) begin
          if (f == 7 || f == 8 || (f == 11 && i < 2))
            pushExp(16*f + 4*i + 4, 4'b1111, 7'b1111111, 1'b1, 0);
          else
            pushExp(16*f + 4*i + 4, pat_an[i], pat_seg[i], pat_dp[i], 1);
        end
      end
    end

    waitEdge(84);
    applyStimulus(4'd0, 4'd2, 4'hC, 4'd7, 1'b1, 1'b0);
    waitEdge(184);
    applyStimulus(4'd0, 4'd2, 4'hC, 4'd7, 1'b0, 1'b0);

    // Asynchronous reset in slot 2 of frame 13, checked before any clk edge.
    waitEdge(220);
    #1 reset = 1'b1;
    #1 checkOutput("async_reset", 4'b1111, 7'b1111111, 1'b1, 1);

    // Restart from scratch: dark for three edges, then slot 0 with S0=7.
    @(negedge clk);
    @(negedge clk);
    pushExp(1, 4'b1111, 7'b1111111, 1'b1, 1);
    pushExp(2, 4'b1111, 7'b1111111, 1'b1, 1);
    pushExp(3, 4'b1111, 7'b1111111, 1'b1, 1);
    pushExp(4, 4'b1110, 7'b1111000, 1'b1, 1);
    reset = 1'b0;

    for (int k = 0; k < 100 && sb_q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    if (sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
